// File: rtl/multiplier_booth_seq_if.sv
// Handshake and operand/result bundle for multiplier_booth_seq.
// The multiplier takes the slave modport; the producer/consumer side takes master.
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both 1. Valid, once raised, is held together with
// its data until that edge, and the data is not changed while valid is high.
// dbg_state mirrors the FSM state register for observation only.
interface multiplier_booth_seq_if #(
  parameter int IA_W  = 16,
  parameter int IB_W  = 16,
  parameter int MUL_W = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [IA_W-1:0]  i_a;
  logic [IB_W-1:0]  i_b;
  logic             i_a_signed;
  logic             i_b_signed;
  logic             o_valid;
  logic             i_ready;
  logic [MUL_W-1:0] o_prod;
  logic             o_busy;
  logic [1:0]       dbg_state;

  modport slave (
    input  i_valid, i_a, i_b, i_a_signed, i_b_signed, i_ready,
    output o_ready, o_valid, o_prod, o_busy, dbg_state
  );

  modport master (
    output i_valid, i_a, i_b, i_a_signed, i_b_signed, i_ready,
    input  o_ready, o_valid, o_prod, o_busy, dbg_state
  );
endinterface

// File: rtl/multiplier_booth_seq.sv
// Sequential radix-4 Booth multiplier, PP_PER_CYC partial products per clock.
// Optional macro MULT_BOOTH_SEQ_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are a pure sign run (all 0 or all 1), since every remaining
// Booth group then encodes 0. Without it latency is a fixed NCYC cycles.
module multiplier_booth_seq #(
  parameter int IA_W       = 16,
  parameter int IB_W       = 16,
  parameter int MUL_W      = 32,
  parameter int PP_PER_CYC = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  multiplier_booth_seq_if.slave bus
);

  localparam int MAX_W  = (IA_W > IB_W) ? IA_W : IB_W;
  localparam int IN_W   = MAX_W + 1;
  localparam int IN_W_E = IN_W + (IN_W % 2);
  localparam int N_PP   = IN_W_E / 2;
  localparam int NCYC   = (N_PP + PP_PER_CYC - 1) / PP_PER_CYC;
  // a_sh carries a[-1] in bit 0 so each Booth group is a plain 3-bit slice.
  localparam int AS_W   = IN_W_E + 1;
  // The product is only observed modulo 2^MUL_W (or sign-extended when MUL_W
  // exceeds 2*IN_W_E, where the exact product already fits), so the
  // accumulator and shifted multiplicand only need max(MUL_W, IN_W_E) bits.
  localparam int ACC_W  = (MUL_W > IN_W_E) ? MUL_W : IN_W_E;
  localparam int CNT_W  = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic signed [AS_W-1:0]  a_sh, a_sh_nxt;
  logic signed [ACC_W-1:0] b_sh, acc, pp_sum;
  logic [CNT_W-1:0]        cnt;
  logic [IN_W_E-1:0]       a_ext, b_ext;
  logic                    accept, last_cyc;

  // Operand extension at capture, selected by the per-operand signed flag.
  assign a_ext  = {{(IN_W_E-IA_W){bus.i_a_signed & bus.i_a[IA_W-1]}}, bus.i_a};
  assign b_ext  = {{(IN_W_E-IB_W){bus.i_b_signed & bus.i_b[IB_W-1]}}, bus.i_b};
  assign accept = bus.i_valid & bus.o_ready;

  // Booth-encode this cycle's groups and sum the shifted partial products.
  always_comb begin
    logic [2:0]              grp;
    logic signed [ACC_W-1:0] term;
    pp_sum = '0;
    grp    = '0;
    term   = '0;
    for (int k = 0; k < PP_PER_CYC; k++) begin
      grp = a_sh[2*k +: 3];
      case (grp)
        3'b001, 3'b010: term = b_sh;
        3'b011:         term = b_sh <<< 1;
        3'b100:         term = -(b_sh <<< 1);
        3'b101, 3'b110: term = -b_sh;
        default:        term = '0;
      endcase
      // Groups past N_PP in a final partial cycle contribute nothing.
      if ((int'(cnt) * PP_PER_CYC + k) < N_PP)
        pp_sum = pp_sum + (term <<< (2*k));
    end
  end

  // Next multiplier window and end-of-operation decision.
  always_comb begin
    a_sh_nxt = a_sh >>> (2*PP_PER_CYC);
`ifdef MULT_BOOTH_SEQ_EARLY_EXIT_EN
    // Arithmetic shift replicates the top bit, so an all-equal window means
    // the unprocessed bits a[IN_W_E-1:2j+1] are a pure sign run.
    last_cyc = (cnt == LAST_CNT) || (a_sh_nxt == '0) || (&a_sh_nxt);
`else
    last_cyc = (cnt == LAST_CNT);
`endif
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and input-side ready.
  always_comb begin
    state_nxt   = state;
    bus.o_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_cyc) state_nxt = DONE;
      end
      DONE: begin
        if (bus.i_ready) begin
          bus.o_ready = 1'b1;
          state_nxt   = bus.i_valid ? BUSY : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, accumulate while busy, hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      a_sh <= {a_ext, 1'b0};
      b_sh <= ACC_W'($signed(b_ext));
      acc  <= '0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      acc  <= acc + pp_sum;
      a_sh <= a_sh_nxt;
      b_sh <= b_sh <<< (2*PP_PER_CYC);
      cnt  <= cnt + 1'b1;
    end
  end

  // Result-side outputs; o_prod reads as zero outside DONE.
  always_comb begin
    bus.o_valid   = (state == DONE);
    bus.o_busy    = (state == BUSY);
    bus.dbg_state = state;
    bus.o_prod    = (state == DONE) ? acc[MUL_W-1:0] : '0;
  end

endmodule

// File: tb/tb_multiplier_booth_seq.sv
// Bench for multiplier_booth_seq: a PP_PER_CYC=1 instance and a PP_PER_CYC=4
// instance, checked against an arithmetic reference model.
module tb_multiplier_booth_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] exp_q[$];

  multiplier_booth_seq_if #(.IA_W(16), .IB_W(16), .MUL_W(32)) bus1();
  multiplier_booth_seq_if #(.IA_W(16), .IB_W(16), .MUL_W(32)) bus4();

  multiplier_booth_seq #(.IA_W(16), .IB_W(16), .MUL_W(32), .PP_PER_CYC(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1)
  );
  multiplier_booth_seq #(.IA_W(16), .IB_W(16), .MUL_W(32), .PP_PER_CYC(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .bus(bus4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint ext_val(input logic [15:0] v, input logic s);
    if (s) return longint'($signed(v));
    return longint'(v);
  endfunction

  function automatic logic [31:0] ref_prod(input logic [15:0] a, b, input logic as, bs);
    longint p;
    p = ext_val(a, as) * ext_val(b, bs);
    return p[31:0];
  endfunction

  // 16-bit operands -> 18-bit extended, 9 Booth groups.
  function automatic int ref_lat(input logic [15:0] a, input logic as, input int pp);
    int ncyc;
    ncyc = (9 + pp - 1) / pp;
`ifdef MULT_BOOTH_SEQ_EARLY_EXIT_EN
    for (int c = 1; c < ncyc; c++) begin
      longint rest;
      rest = ext_val(a, as) >>> (2*pp*c - 1);
      if (rest == 0 || rest == -1) return c;
    end
`endif
    return ncyc;
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'($urandom_range(0, 15));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  // ---------------- drivers (called at a negedge) ----------------
  task automatic drive_op1(input logic [15:0] a, b, input logic as, bs,
                           output logic [31:0] prod, output int lat);
    int w = 0;
    while (!bus1.o_ready && w < 100) begin @(negedge clk); w++; end
    bus1.i_a = a; bus1.i_b = b; bus1.i_a_signed = as; bus1.i_b_signed = bs;
    bus1.i_valid = 1'b1; bus1.i_ready = 1'b1;
    @(negedge clk);
    bus1.i_valid = 1'b0;
    bus1.i_a = 16'($urandom); bus1.i_b = 16'($urandom);
    bus1.i_a_signed = 1'($urandom); bus1.i_b_signed = 1'($urandom);
    lat = 0;
    while (!bus1.o_valid && lat < 100) begin @(negedge clk); lat++; end
    prod = bus1.o_prod;
    @(negedge clk);
  endtask

  task automatic drive_op4(input logic [15:0] a, b, input logic as, bs,
                           output logic [31:0] prod, output int lat);
    int w = 0;
    while (!bus4.o_ready && w < 100) begin @(negedge clk); w++; end
    bus4.i_a = a; bus4.i_b = b; bus4.i_a_signed = as; bus4.i_b_signed = bs;
    bus4.i_valid = 1'b1; bus4.i_ready = 1'b1;
    @(negedge clk);
    bus4.i_valid = 1'b0;
    bus4.i_a = 16'($urandom); bus4.i_b = 16'($urandom);
    lat = 0;
    while (!bus4.o_valid && lat < 100) begin @(negedge clk); lat++; end
    prod = bus4.o_prod;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus1.o_valid !== 1'b0) $display("FAIL reset_o_valid got %b exp 0", bus1.o_valid); else n_pass++;
    n_checks++; if (bus1.o_busy !== 1'b0) $display("FAIL reset_o_busy got %b exp 0", bus1.o_busy); else n_pass++;
    n_checks++; if (bus1.o_prod !== 32'h0) $display("FAIL reset_o_prod got %h exp 0", bus1.o_prod); else n_pass++;
    n_checks++; if (bus1.o_ready !== 1'b1) $display("FAIL reset_o_ready got %b exp 1", bus1.o_ready); else n_pass++;
    n_checks++; if (bus4.o_ready !== 1'b1) $display("FAIL reset_o_ready_pp4 got %b exp 1", bus4.o_ready); else n_pass++;
  endtask

  task automatic test_directed();
    logic [15:0] ta[7] = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h0003, 16'h0000, 16'h0007};
    logic [15:0] tb[7] = '{16'hFFFF, 16'h8000, 16'h0003, 16'hFFFF, 16'h0005, 16'h1234, 16'h0006};
    logic        tas[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        tbs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] tp[7] = '{32'hFFFE0001, 32'h40000000, 32'hFFFFFFFD, 32'hFFFF0001,
                           32'd15, 32'd0, 32'd42};
    logic [31:0] prod;
    int lat, exp_lat;
    for (int i = 0; i < 7; i++) begin
      drive_op1(ta[i], tb[i], tas[i], tbs[i], prod, lat);
      exp_lat = ref_lat(ta[i], tas[i], 1);
      n_checks++; if (prod !== tp[i]) $display("FAIL directed_prod[%0d] got %h exp %h", i, prod, tp[i]); else n_pass++;
      n_checks++; if (lat != exp_lat) $display("FAIL directed_lat[%0d] got %0d exp %0d", i, lat, exp_lat); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a2, b2;
    logic [31:0] exp1, exp2;
    int lat;
    exp1 = ref_prod(16'h1234, 16'h5678, 1'b0, 1'b0);
    bus1.i_a = 16'h1234; bus1.i_b = 16'h5678; bus1.i_a_signed = 1'b0; bus1.i_b_signed = 1'b0;
    bus1.i_valid = 1'b1; bus1.i_ready = 1'b0;
    @(negedge clk);
    bus1.i_valid = 1'b0;
    lat = 0;
    while (!bus1.o_valid && lat < 100) begin @(negedge clk); lat++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus1.o_valid !== 1'b1) $display("FAIL hold_o_valid[%0d] got %b exp 1", i, bus1.o_valid); else n_pass++;
      n_checks++; if (bus1.o_prod !== exp1) $display("FAIL hold_o_prod[%0d] got %h exp %h", i, bus1.o_prod, exp1); else n_pass++;
      n_checks++; if (bus1.o_ready !== 1'b0) $display("FAIL hold_o_ready[%0d] got %b exp 0", i, bus1.o_ready); else n_pass++;
      @(negedge clk);
    end
    a2 = 16'($urandom); b2 = 16'($urandom);
    exp2 = ref_prod(a2, b2, 1'b1, 1'b1);
    bus1.i_a = a2; bus1.i_b = b2; bus1.i_a_signed = 1'b1; bus1.i_b_signed = 1'b1;
    bus1.i_valid = 1'b1; bus1.i_ready = 1'b1;
    #1;
    n_checks++; if (bus1.o_ready !== 1'b1) $display("FAIL b2b_o_ready got %b exp 1", bus1.o_ready); else n_pass++;
    @(negedge clk);
    bus1.i_valid = 1'b0;
    bus1.i_a = 16'($urandom); bus1.i_b = 16'($urandom);
    n_checks++; if (bus1.o_busy !== 1'b1) $display("FAIL b2b_o_busy got %b exp 1", bus1.o_busy); else n_pass++;
    n_checks++; if (bus1.o_valid !== 1'b0) $display("FAIL b2b_o_valid got %b exp 0", bus1.o_valid); else n_pass++;
    lat = 0;
    while (!bus1.o_valid && lat < 100) begin @(negedge clk); lat++; end
    n_checks++; if (lat != ref_lat(a2, 1'b1, 1)) $display("FAIL b2b_lat got %0d exp %0d", lat, ref_lat(a2, 1'b1, 1)); else n_pass++;
    n_checks++; if (bus1.o_prod !== exp2) $display("FAIL b2b_prod got %h exp %h", bus1.o_prod, exp2); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] prod;
    int lat;
    bus1.i_a = 16'hABCD; bus1.i_b = 16'h1357; bus1.i_a_signed = 1'b0; bus1.i_b_signed = 1'b0;
    bus1.i_valid = 1'b1; bus1.i_ready = 1'b1;
    @(negedge clk);
    bus1.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus1.o_valid !== 1'b0) $display("FAIL midrst_o_valid got %b exp 0", bus1.o_valid); else n_pass++;
    n_checks++; if (bus1.o_busy !== 1'b0) $display("FAIL midrst_o_busy got %b exp 0", bus1.o_busy); else n_pass++;
    n_checks++; if (bus1.o_prod !== 32'h0) $display("FAIL midrst_o_prod got %h exp 0", bus1.o_prod); else n_pass++;
    n_checks++; if (bus1.o_ready !== 1'b1) $display("FAIL midrst_o_ready got %b exp 1", bus1.o_ready); else n_pass++;
    drive_op1(16'd7, 16'd6, 1'b0, 1'b0, prod, lat);
    n_checks++; if (prod !== 32'd42) $display("FAIL midrst_prod got %h exp %h", prod, 32'd42); else n_pass++;
    n_checks++; if (lat != ref_lat(16'd7, 1'b0, 1)) $display("FAIL midrst_lat got %0d exp %0d", lat, ref_lat(16'd7, 1'b0, 1)); else n_pass++;
  endtask

  task automatic test_random_pp1(input int n);
    logic [15:0] a, b;
    logic as, bs;
    logic [31:0] prod, exp;
    int lat, exp_lat;
    for (int i = 0; i < n; i++) begin
      a = pick_operand(); b = pick_operand();
      as = 1'($urandom); bs = 1'($urandom);
      exp_q.push_back(ref_prod(a, b, as, bs));
      exp_lat = ref_lat(a, as, 1);
      drive_op1(a, b, as, bs, prod, lat);
      exp = exp_q.pop_front();
      n_checks++; if (prod !== exp) $display("FAIL rand1_prod a=%h b=%h s=%b%b got %h exp %h", a, b, as, bs, prod, exp); else n_pass++;
      n_checks++; if (lat != exp_lat) $display("FAIL rand1_lat a=%h got %0d exp %0d", a, lat, exp_lat); else n_pass++;
    end
  endtask

  task automatic test_random_pp4(input int n);
    logic [15:0] a, b;
    logic as, bs;
    logic [31:0] prod, exp;
    int lat, exp_lat;
    for (int i = 0; i < n; i++) begin
      a = pick_operand(); b = pick_operand();
      as = 1'($urandom); bs = 1'($urandom);
      exp_q.push_back(ref_prod(a, b, as, bs));
      exp_lat = ref_lat(a, as, 4);
      drive_op4(a, b, as, bs, prod, lat);
      exp = exp_q.pop_front();
      n_checks++; if (prod !== exp) $display("FAIL rand4_prod a=%h b=%h s=%b%b got %h exp %h", a, b, as, bs, prod, exp); else n_pass++;
      n_checks++; if (lat != exp_lat) $display("FAIL rand4_lat a=%h got %0d exp %0d", a, lat, exp_lat); else n_pass++;
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    bus1.i_valid = 1'b0; bus1.i_ready = 1'b1; bus1.i_a = '0; bus1.i_b = '0;
    bus1.i_a_signed = 1'b0; bus1.i_b_signed = 1'b0;
    bus4.i_valid = 1'b0; bus4.i_ready = 1'b1; bus4.i_a = '0; bus4.i_b = '0;
    bus4.i_a_signed = 1'b0; bus4.i_b_signed = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random_pp1(300);
    test_random_pp4(8000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
